// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a
// per-register pending-producer (busy) scoreboard for RAW hazard detection.
// Port 1 has priority over port 0 on both the write path and the bypass path.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_dest,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic              wr0_ok;
  logic              wr1_ok;

  // Writes to the hardwired zero register are dropped.
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Storage update; port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        mem_q[waddr0] <= wdata0;
      end
      if (wr1_ok) begin
        mem_q[waddr1] <= wdata1;
      end
    end
  end

  // Next busy vector: writeback clears, issue sets, and a new producer
  // supersedes one completing in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (we0 && (waddr0 == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (we1 && (waddr1 == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (issue_valid && (issue_dest == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Population count of the next busy vector, registered alongside busy_q.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  // Scoreboard state; reset discards every pending producer.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: zero register, then port 1 bypass, then port 0 bypass, then
  // storage. A register being written this cycle is final, hence not busy.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              hit0;
    logic              hit1;

    assign ra      = raddr[i*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit0    = we0 && (waddr0 == ra);
    assign hit1    = we1 && (waddr1 == ra);

    assign rdata[i*DATA_W +: DATA_W] = is_zero ? {DATA_W{1'b0}} :
                                       hit1    ? wdata1 :
                                       hit0    ? wdata0 :
                                                 mem_q[ra];
    assign rbusy[i] = busy_q[ra] && !hit0 && !hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of the default configuration and of a
// 4-read-port, 8-entry, no-zero-register configuration.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default configuration: DATA_W=32 ADDR_W=5 NREAD=2 ZERO_REG=1
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        we0, we1, issue_valid;
  logic [4:0]  waddr0, waddr1, issue_dest;
  logic [31:0] wdata0, wdata1;
  logic [5:0]  busy_cnt;

  regfile_mp u_dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .busy_cnt(busy_cnt)
  );

  // sweep configuration
  logic        s_reset;
  logic [11:0] s_raddr;
  logic [63:0] s_rdata;
  logic [3:0]  s_rbusy;
  logic        s_we0, s_we1, s_issue_valid;
  logic [2:0]  s_waddr0, s_waddr1, s_issue_dest;
  logic [15:0] s_wdata0, s_wdata1;
  logic [3:0]  s_busy_cnt;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(0)) u_sw (
    .clk(clk), .reset(s_reset), .raddr(s_raddr), .rdata(s_rdata), .rbusy(s_rbusy),
    .we0(s_we0), .waddr0(s_waddr0), .wdata0(s_wdata0),
    .we1(s_we1), .waddr1(s_waddr1), .wdata1(s_wdata1),
    .issue_valid(s_issue_valid), .issue_dest(s_issue_dest), .busy_cnt(s_busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; issue_dest = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic s_idle();
    s_we0 = 1'b0; s_we1 = 1'b0; s_issue_valid = 1'b0;
    s_waddr0 = '0; s_waddr1 = '0; s_issue_dest = '0;
    s_wdata0 = '0; s_wdata1 = '0;
  endtask

  // step to just after the next rising edge
  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    s_idle();
    raddr = '0;
    s_raddr = '0;
    reset = 1'b1;
    s_reset = 1'b1;
    // reset dominates a write to register 3
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD;
    @(negedge clk);
    post_edge();
    @(negedge clk);
    reset = 1'b0;
    s_reset = 1'b0;
    idle();
    #1;
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("rst_rdata0_a%0d", a), rdata[31:0], 64'd0);
      chk($sformatf("rst_rdata1_a%0d", 31 - a), rdata[63:32], 64'd0);
      chk($sformatf("rst_rbusy_a%0d", a), 64'(rbusy), 64'd0);
    end

    // both ports write register 5: port 1 wins the bypass and the store
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22;
    raddr = {5'd6, 5'd5};
    #1;
    chk("byp_pri_rd0", rdata[31:0], 64'h22);
    chk("byp_other_rd1", rdata[63:32], 64'h0);
    @(negedge clk);
    idle();
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h33;
    #1;
    chk("stored_pri_rd0", rdata[31:0], 64'h22);
    chk("byp_port0_rd1", rdata[63:32], 64'h33);
    @(negedge clk);
    idle();
    #1;
    chk("stored_rd1", rdata[63:32], 64'h33);

    // zero register ignores writes and issue
    @(negedge clk);
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_dest = 5'd0;
    raddr = {5'd6, 5'd0};
    #1;
    chk("zero_byp_rd0", rdata[31:0], 64'h0);
    chk("zero_byp_busy", 64'(rbusy), 64'h0);
    post_edge();
    chk("zero_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("zero_rd0", rdata[31:0], 64'h0);
    chk("zero_busy", 64'(rbusy), 64'h0);

    // scoreboard: issue 7, then writeback 7
    @(negedge clk);
    issue_valid = 1'b1; issue_dest = 5'd7;
    raddr = {5'd6, 5'd7};
    #1;
    chk("sb_issue_same_cycle_busy", 64'(rbusy), 64'h0);
    post_edge();
    chk("sb_issued_busy", 64'(rbusy), 64'h1);
    chk("sb_issued_cnt", 64'(busy_cnt), 64'd1);
    @(negedge clk);
    idle();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1234;
    #1;
    chk("sb_wb_rd0", rdata[31:0], 64'h1234);
    chk("sb_wb_busy", 64'(rbusy), 64'h0);
    post_edge();
    chk("sb_wb_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("sb_after_rd0", rdata[31:0], 64'h1234);
    chk("sb_after_busy", 64'(rbusy), 64'h0);

    // set beats clear on register 9
    @(negedge clk);
    issue_valid = 1'b1; issue_dest = 5'd9;
    raddr = {5'd10, 5'd9};
    post_edge();
    chk("sbc_cnt_before", 64'(busy_cnt), 64'd1);
    @(negedge clk);
    idle();
    issue_valid = 1'b1; issue_dest = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hAAAA_5555;
    #1;
    chk("sbc_byp_rd0", rdata[31:0], 64'hAAAA_5555);
    chk("sbc_byp_busy", 64'(rbusy), 64'h0);
    post_edge();
    chk("sbc_cnt_after", 64'(busy_cnt), 64'd1);
    @(negedge clk);
    idle();
    #1;
    chk("sbc_rd0", rdata[31:0], 64'hAAAA_5555);
    chk("sbc_busy", 64'(rbusy), 64'h1);

    // issue 10 while writeback clears 9
    @(negedge clk);
    issue_valid = 1'b1; issue_dest = 5'd10;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    post_edge();
    chk("mix_cnt", 64'(busy_cnt), 64'd1);
    @(negedge clk);
    idle();
    #1;
    chk("mix_busy", 64'(rbusy), 64'b10);
    chk("mix_rd0", rdata[31:0], 64'h99);

    // issue 11, then reset dominating issue and write
    @(negedge clk);
    issue_valid = 1'b1; issue_dest = 5'd11;
    post_edge();
    chk("pre_rst_cnt", 64'(busy_cnt), 64'd2);
    @(negedge clk);
    idle();
    reset = 1'b1;
    issue_valid = 1'b1; issue_dest = 5'd12;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h4444;
    post_edge();
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
    chk("mid_rst_busy", 64'(rbusy), 64'h0);
    chk("mid_rst_rd9", rdata[31:0], 64'h0);
    raddr = {5'd12, 5'd4};
    #1;
    chk("mid_rst_rd4", rdata[31:0], 64'h0);
    chk("mid_rst_busy12", 64'(rbusy), 64'h0);

    // late writeback to a non-busy register
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h77;
    raddr = {5'd10, 5'd4};
    post_edge();
    chk("late_wb_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("late_wb_rd1", rdata[63:32], 64'h77);
    chk("late_wb_busy", 64'(rbusy), 64'h0);

    // sweep configuration: fill the scoreboard including register 0
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      s_issue_valid = 1'b1; s_issue_dest = 3'(r);
      post_edge();
      chk($sformatf("sw_cnt_%0d", r), 64'(s_busy_cnt), 64'(r + 1));
    end
    @(negedge clk);
    s_idle();
    s_raddr = {3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    chk("sw_all_busy", 64'(s_rbusy), 64'hF);
    chk("sw_rd_reset_val", s_rdata, 64'h0);

    // write register 0 and 5 while 6 and 7 stay busy
    @(negedge clk);
    s_we0 = 1'b1; s_waddr0 = 3'd0; s_wdata0 = 16'hBEEF;
    s_we1 = 1'b1; s_waddr1 = 3'd5; s_wdata1 = 16'h1234;
    s_raddr = {3'd7, 3'd6, 3'd5, 3'd0};
    #1;
    chk("sw_byp_rd", s_rdata, 64'h0000_0000_1234_BEEF);
    chk("sw_byp_busy", 64'(s_rbusy), 64'b1100);
    post_edge();
    chk("sw_wb_cnt", 64'(s_busy_cnt), 64'd6);
    @(negedge clk);
    s_idle();
    #1;
    chk("sw_stored_rd", s_rdata, 64'h0000_0000_1234_BEEF);
    chk("sw_stored_busy", 64'(s_rbusy), 64'b1100);

    // both ports on register 2
    @(negedge clk);
    s_we0 = 1'b1; s_waddr0 = 3'd2; s_wdata0 = 16'h1111;
    s_we1 = 1'b1; s_waddr1 = 3'd2; s_wdata1 = 16'h2222;
    s_raddr = {3'd3, 3'd2, 3'd1, 3'd2};
    #1;
    chk("sw_pri_byp", s_rdata, 64'h0000_2222_0000_2222);
    post_edge();
    chk("sw_pri_cnt", 64'(s_busy_cnt), 64'd5);
    @(negedge clk);
    s_idle();
    #1;
    chk("sw_pri_stored", s_rdata, 64'h0000_2222_0000_2222);
    chk("sw_pri_busy", 64'(s_rbusy), 64'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
